data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Shares the single-port data memory (64 KiB, byte-addressed, little-endian word access, synchronous write, combinational read) between two requesters: port 0 = processor load/store unit, port 1 = loader/debug master.
- Latches one request and drives the memory port for exactly one cycle.
- Returns read data or a write acknowledgement, with an error flag for illegal addresses.
- Sits between the pipeline MEM stage / loader and data_memory.

Parameters:
- MEM_BYTES, 65536, memory size in bytes; legal word addresses are 0 .. MEM_BYTES-4.
- DATA_WIDTH, 32, word width (fixed 32; parameter documents intent only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 request; held high with fields stable until m0_ack.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 write data.
- m0_ack  out  1  port 0 completion pulse, one cycle.
- m0_err  out  1  port 0 error, valid with m0_ack.
- m0_rdata  out  32  port 0 read data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same as port 0, for port 1.
- mem_address  out  32  to data_memory address.
- mem_memWrite  out  1  to data_memory memWrite.
- mem_writeData  out  32  to data_memory writeData.
- mem_readData  in  32  from data_memory readData.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (immediate, asynchronous): state=IDLE; all ack/err=0; rdata=0; mem_address=0; mem_memWrite=0; mem_writeData=0; busy=0; priority pointer=port 0.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: if any req is high, select a winner and latch its we/addr/wdata and its port id.
  - Address legal (addr[1:0]==0 and addr <= MEM_BYTES-4): go to ACCESS.
  - Otherwise: set err_pending and go to RESP without touching memory.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr; mem_memWrite = latched we; mem_writeData = latched wdata.
  - Write commits at the closing edge.
  - For a read, mem_readData is captured into the winner's rdata register at the closing edge.
  - Next state: RESP.
- RESP (1 cycle):
  - Winner's ack=1.
  - err=1 if err_pending; on error, rdata=0.
  - On a write, rdata holds its previous value.
  - mem_memWrite=0. Next state: IDLE.
- Latency: req sampled in cycle N, memory access in N+1, ack in N+2. The next grant is decided in N+3. Throughput is one access per 3 cycles.
- Arbitration: fixed priority, port 0 wins on simultaneous requests.
- A loser keeps req high and is served in the next IDLE cycle.
- Non-winner ack/err are always 0. Never more than one ack high at a time.
- mem_memWrite is high only in ACCESS with we=1; it is never high in IDLE, RESP or on an illegal address.
- Requester drops req after the grant: the transaction still completes on latched fields and ack still pulses.
- Requester still holding req in the ack cycle is treated as a new request in the following IDLE cycle. Requesters must drop req on ack.
- Reset asserted during ACCESS: mem_memWrite falls immediately and the write may be lost. No ack is issued.
- Address 65532 is legal. Addresses 65533, 65536, 0xFFFFFFFC and any misaligned address return err, and memory is unchanged.

Optional Feature:
- ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the port that did not win the last grant wins. The pointer updates on every grant, including error grants.
- Undefined: fixed priority, port 0 always wins, and port 1 can starve.

Test Plan:
- Port 0 writes addr 0x10, data 0xDEADBEEF, then reads addr 0x10 -> write ack at N+2 with err=0; read ack with m0_rdata=0xDEADBEEF; mem_memWrite high for exactly one cycle.
- m0_req and m1_req rise in the same cycle (reads of 0x0 and 0x4) -> m0_ack at N+2, m1_ack at N+5, never both high; with ROUND_ROBIN_EN and last winner=0, m1 is served first.
- Port 1 reads addr 0x2 (misaligned) and then addr 0x10000 -> each ack'd with m1_err=1 and rdata=0; mem_memWrite stays 0 and memory is unchanged.
- Port 0 writes 0x11223344 to addr 65532, then reads it back -> rdata=0x11223344, err=0; bytes 65532..65535 = 0x44, 0x33, 0x22, 0x11.
- Reset pulsed during ACCESS of a write -> ack/busy/mem_memWrite drop immediately; state=IDLE after release; a following read is served normally.
- Port 0 holds req continuously for 4 back-to-back reads -> acks exactly 3 cycles apart; busy low only in the IDLE cycles.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of the single-port data memory: one access per grant, registered responses.
// Optional build macro ROUND_ROBIN_EN alternates the winner on simultaneous requests (default: port 0 wins).
module data_memory_arbiter #(
    parameter int MEM_BYTES  = 65536,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [31:0]           mem_address,
    output logic                  mem_memWrite,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    input  logic [DATA_WIDTH-1:0] mem_readData,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nx;
    logic                  lat_port, lat_port_nx;
    logic                  lat_we, lat_we_nx;
    logic                  m0_ack_nx, m1_ack_nx, m0_err_nx, m1_err_nx;
    logic [DATA_WIDTH-1:0] m0_rdata_nx, m1_rdata_nx;
    logic [31:0]           mem_address_nx;
    logic                  mem_memWrite_nx;
    logic [DATA_WIDTH-1:0] mem_writeData_nx;
    logic                  win;
    logic [31:0]           sel_addr;
`ifdef ROUND_ROBIN_EN
    logic                  last_win, last_win_nx;
`endif

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'(MEM_BYTES - 4));
    endfunction

    always_comb begin
`ifdef ROUND_ROBIN_EN
        win = (m0_req && m1_req) ? ~last_win : m1_req;
`else
        win = ~m0_req;
`endif
        sel_addr = win ? m1_addr : m0_addr;
    end

    always_comb begin
        state_nx         = state;
        lat_port_nx      = lat_port;
        lat_we_nx        = lat_we;
        m0_ack_nx        = 1'b0;
        m1_ack_nx        = 1'b0;
        m0_err_nx        = 1'b0;
        m1_err_nx        = 1'b0;
        m0_rdata_nx      = m0_rdata;
        m1_rdata_nx      = m1_rdata;
        mem_address_nx   = mem_address;
        mem_memWrite_nx  = 1'b0;
        mem_writeData_nx = mem_writeData;
`ifdef ROUND_ROBIN_EN
        last_win_nx      = last_win;
`endif
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    lat_port_nx = win;
                    lat_we_nx   = win ? m1_we : m0_we;
`ifdef ROUND_ROBIN_EN
                    last_win_nx = win;
`endif
                    if (addr_legal(sel_addr)) begin
                        mem_address_nx   = sel_addr;
                        mem_writeData_nx = win ? m1_wdata : m0_wdata;
                        mem_memWrite_nx  = win ? m1_we : m0_we;
                        state_nx         = ACCESS;
                    end else begin
                        // Illegal address: answer with an error straight away, memory untouched
                        if (win) begin
                            m1_ack_nx   = 1'b1;
                            m1_err_nx   = 1'b1;
                            m1_rdata_nx = '0;
                        end else begin
                            m0_ack_nx   = 1'b1;
                            m0_err_nx   = 1'b1;
                            m0_rdata_nx = '0;
                        end
                        state_nx = RESP;
                    end
                end
            end
            ACCESS: begin
                if (lat_port) begin
                    m1_ack_nx = 1'b1;
                    if (!lat_we) m1_rdata_nx = mem_readData;
                end else begin
                    m0_ack_nx = 1'b1;
                    if (!lat_we) m0_rdata_nx = mem_readData;
                end
                state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lat_port      <= 1'b0;
            lat_we        <= 1'b0;
            m0_ack        <= 1'b0;
            m1_ack        <= 1'b0;
            m0_err        <= 1'b0;
            m1_err        <= 1'b0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
            mem_address   <= '0;
            mem_memWrite  <= 1'b0;
            mem_writeData <= '0;
            busy          <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_win      <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            lat_port      <= lat_port_nx;
            lat_we        <= lat_we_nx;
            m0_ack        <= m0_ack_nx;
            m1_ack        <= m1_ack_nx;
            m0_err        <= m0_err_nx;
            m1_err        <= m1_err_nx;
            m0_rdata      <= m0_rdata_nx;
            m1_rdata      <= m1_rdata_nx;
            mem_address   <= mem_address_nx;
            mem_memWrite  <= mem_memWrite_nx;
            mem_writeData <= mem_writeData_nx;
            busy          <= (state_nx != IDLE);
`ifdef ROUND_ROBIN_EN
            last_win      <= last_win_nx;
`endif
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: byte-wide memory model, vector table, scoreboard and corner sequences.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, busy;

    always #5 clk = ~clk;

    data_memory_arbiter #(.MEM_BYTES(65536), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_memWrite(mem_memWrite),
        .mem_writeData(mem_writeData), .mem_readData(mem_readData),
        .busy(busy)
    );

    // Data memory model: byte array, little-endian word, sync write, combinational read
    logic [7:0]  mem [0:65535];
    logic [15:0] ma;
    assign ma = mem_address[15:0];
    assign mem_readData = {mem[ma + 16'd3], mem[ma + 16'd2], mem[ma + 16'd1], mem[ma]};
    always @(posedge clk) begin
        if (mem_memWrite) begin
            mem[ma]         <= mem_writeData[7:0];
            mem[ma + 16'd1] <= mem_writeData[15:8];
            mem[ma + 16'd2] <= mem_writeData[23:16];
            mem[ma + 16'd3] <= mem_writeData[31:24];
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[12];

    function automatic void push_exp(input logic p, input logic e, input logic [31:0] d);
        exp_t x;
        x.port  = p;
        x.err   = e;
        x.rdata = d;
        sbq.push_back(x);
    endfunction

    // Response monitor: every ack is matched against the oldest expected response
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_memWrite) wr_cnt++;
            if (m0_ack || m1_ack) begin
                exp_t e;
                logic p;
                p = m1_ack;
                chk("ack_onehot", 32'(m0_ack & m1_ack), 32'd0);
                chk("loser_err", 32'(p ? m0_err : m1_err), 32'd0);
                chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("ack_port", 32'(p), 32'(e.port));
                    chk("ack_err", 32'(p ? m1_err : m0_err), 32'(e.err));
                    chk("ack_rdata", p ? m1_rdata : m0_rdata, e.rdata);
                end
            end
        end
    end

    task automatic do_txn(input vec_t v, input string name);
        int c0, w0, lat;
        bit got;
        @(posedge clk);
        #1;
        c0 = cyc;
        w0 = wr_cnt;
        got = 1'b0;
        lat = 0;
        push_exp(v.port, v.exp_err, v.exp_rdata);
        if (v.port) begin
            m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1;
        end else begin
            m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_req = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (v.port ? m1_ack : m0_ack) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk({name, "_ack_seen"}, 32'(got), 32'd1);
        if (got) chk({name, "_latency"}, 32'(lat), v.exp_err ? 32'd1 : 32'd2);
        else sbq.delete();
        chk({name, "_write_cycles"}, 32'(wr_cnt - w0), 32'((!v.exp_err && v.we) ? 1 : 0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t0, t1, n, idle_cnt;
        int t[4];
        bit g0, g1;

        vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h2,        32'h0,        1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h10000,    32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'd65532,    32'h11223344, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b0, 32'd65532,    32'h0,        1'b0, 32'h11223344};
        vecs[6]  = '{1'b1, 1'b0, 32'd65533,    32'h0,        1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'h55,       1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 1'b1, 32'h4,        32'hA5A5A5A5, 1'b0, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 1'b1, 32'h0,        32'h0BADF00D, 1'b0, 32'h11223344};
        vecs[11] = '{1'b0, 1'b0, 32'h4,        32'h0,        1'b0, 32'hA5A5A5A5};

        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_m0_err", 32'(m0_err), 32'd0);
        chk("rst_m1_err", 32'(m1_err), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_memWrite", 32'(mem_memWrite), 32'd0);
        chk("rst_mem_writeData", mem_writeData, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        chk("byte_65532", 32'(mem[65532]), 32'h44);
        chk("byte_65533", 32'(mem[65533]), 32'h33);
        chk("byte_65534", 32'(mem[65534]), 32'h22);
        chk("byte_65535", 32'(mem[65535]), 32'h11);

        // Simultaneous requests; last grant went to port 0
        @(posedge clk);
        #1;
        c0 = cyc;
`ifdef ROUND_ROBIN_EN
        push_exp(1'b1, 1'b0, 32'hA5A5A5A5);
        push_exp(1'b0, 1'b0, 32'h0BADF00D);
`else
        push_exp(1'b0, 1'b0, 32'h0BADF00D);
        push_exp(1'b1, 1'b0, 32'hA5A5A5A5);
`endif
        m0_we = 1'b0; m0_addr = 32'h0; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 32'h4; m1_req = 1'b1;
        g0 = 1'b0; g1 = 1'b0; t0 = -1; t1 = -1;
        for (int i = 0; i < 30 && !(g0 && g1); i++) begin
            @(negedge clk);
            if (m0_ack) begin g0 = 1'b1; t0 = cyc - c0; m0_req = 1'b0; end
            if (m1_ack) begin g1 = 1'b1; t1 = cyc - c0; m1_req = 1'b0; end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
`ifdef ROUND_ROBIN_EN
        chk("sim_m0_cycle", 32'(t0), 32'd5);
        chk("sim_m1_cycle", 32'(t1), 32'd2);
`else
        chk("sim_m0_cycle", 32'(t0), 32'd2);
        chk("sim_m1_cycle", 32'(t1), 32'd5);
`endif
        if (!(g0 && g1)) sbq.delete();

        // Port 0 holds req for four back-to-back reads
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        m0_we = 1'b0; m0_addr = 32'h10; m0_req = 1'b1;
        n = 0;
        idle_cnt = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (!busy && n >= 1) idle_cnt++;
            if (m0_ack) begin
                t[n] = cyc - c0;
                n++;
                if (n == 4) m0_req = 1'b0;
            end
        end
        m0_req = 1'b0;
        chk("b2b_ack_count", 32'(n), 32'd4);
        if (n == 4) begin
            chk("b2b_first_latency", 32'(t[0]), 32'd2);
            for (int k = 1; k < 4; k++) chk($sformatf("b2b_gap%0d", k), 32'(t[k] - t[k-1]), 32'd3);
            chk("b2b_idle_cycles", 32'(idle_cnt), 32'd3);
        end else begin
            sbq.delete();
        end

        // Reset pulsed during the ACCESS cycle of a write
        @(posedge clk);
        #1;
        m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hCAFEBABE; m0_req = 1'b1;
        @(posedge clk);
        #2;
        chk("rstacc_memWrite_before", 32'(mem_memWrite), 32'd1);
        chk("rstacc_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstacc_memWrite", 32'(mem_memWrite), 32'd0);
        chk("rstacc_busy", 32'(busy), 32'd0);
        chk("rstacc_ack", 32'(m0_ack | m1_ack), 32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstacc_idle_after", 32'(busy), 32'd0);
        do_txn('{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF}, "post_reset_read");

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
